eth_tx_sched: RTL

Transmit frame scheduler for the RMII/GMII Ethernet framing path. It queues up to DEPTH transmit descriptors, each giving a base address and a byte length in the tx packet buffer. It launches them one at a time into the gmii_tx byte engine, waits for each frame to complete, and then enforces an inter-frame gap before starting the next. It lives entirely in the clk_rmii domain; descriptor writes from msoc_clk are synchronised outside this block.

---
 rtl/eth_tx_sched_if.sv | 37 +++
 rtl/eth_tx_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched_if.sv
// rtl/eth_tx_sched_if.sv - descriptor, engine and status signals of eth_tx_sched
interface eth_tx_sched_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 11
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_base;
  logic [LEN_W-1:0]  desc_len;
  logic              flush;
  logic              tx_start;
  logic [ADDR_W-1:0] tx_base;
  logic [LEN_W-1:0]  tx_len;
  logic              tx_done;
  logic              tx_kill;
  logic              busy;
  logic [CNT_W-1:0]  q_count;
  logic [7:0]        done_count;
  logic              err_timeout;
  logic              irq;
  logic              irq_ack;

  modport master (
    output desc_valid, desc_base, desc_len, flush, tx_done, irq_ack,
    input  desc_ready, tx_start, tx_base, tx_len, tx_kill, busy, q_count,
           done_count, err_timeout, irq
  );

  modport slave (
    input  desc_valid, desc_base, desc_len, flush, tx_done, irq_ack,
    output desc_ready, tx_start, tx_base, tx_len, tx_kill, busy, q_count,
           done_count, err_timeout, irq
  );
endinterface

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - tx descriptor queue and frame launcher with inter-frame gap
// Optional ACTIVE watchdog enabled by defining ETH_TX_SCHED_WATCHDOG_EN.
module eth_tx_sched #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 11,
  parameter int LEN_W       = 11,
  parameter int IFG_CYCLES  = 48,
  parameter int WDOG_CYCLES = 8192
) (
  input  logic           clk_rmii,
  input  logic           rstn,
  eth_tx_sched_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_ACTIVE,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_base_mem [DEPTH];
  logic [LEN_W-1:0]  r_len_mem  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_tx_base;
  logic [LEN_W-1:0]  r_tx_len;
  logic [GAP_W-1:0]  r_gap;
  logic [7:0]        r_done_cnt;
  logic              r_irq;

  logic              w_desc_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_done;
  logic              w_kill;
  logic              w_q_empty;
  logic [ADDR_W-1:0] w_head_base;
  logic [LEN_W-1:0]  w_head_len;

`ifdef ETH_TX_SCHED_WATCHDOG_EN
  localparam logic [12:0] WDOG_LAST = 13'(WDOG_CYCLES - 1);
  logic [12:0]       r_wdog;
  logic              r_err;
`else
  localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
`endif

  assign w_desc_ready = rstn & ~bus.flush & (r_count != CNT_W'(DEPTH));
  assign w_push       = bus.desc_valid & w_desc_ready;
  assign w_q_empty    = (r_count == '0);
  assign w_head_base  = r_base_mem[r_rd_ptr];
  assign w_head_len   = r_len_mem[r_rd_ptr];

  always_ff @(posedge clk_rmii) begin
    if (w_push) begin
      r_base_mem[r_wr_ptr] <= bus.desc_base;
      r_len_mem[r_wr_ptr]  <= bus.desc_len;
    end
  end

  // flush realigns the read pointer onto the write pointer; a push is never
  // accepted in the same cycle because desc_ready is low.
  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_rmii) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Head fields are captured on the IDLE->START transition so tx_base/tx_len
  // are already valid while tx_start is high.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_kill      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.flush && !w_q_empty) begin
          if (w_head_len != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      S_START: begin
        w_pop       = 1'b1;
        w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (bus.tx_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_GAP;
        end
`ifdef ETH_TX_SCHED_WATCHDOG_EN
        else if (r_wdog == WDOG_LAST) begin
          w_kill      = 1'b1;
          w_state_nxt = S_GAP;
        end
`endif
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      r_tx_base  <= '0;
      r_tx_len   <= '0;
      r_gap      <= '0;
      r_done_cnt <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_base <= w_head_base;
        r_tx_len  <= w_head_len;
      end
      if (w_done || w_kill)
        r_gap <= GAP_W'(IFG_CYCLES - 1);
      else if (r_state == S_GAP && r_gap != '0)
        r_gap <= r_gap - GAP_W'(1);
      if (w_done) r_done_cnt <= r_done_cnt + 8'd1;
      if (w_done || w_kill) r_irq <= 1'b1;
      else if (bus.irq_ack) r_irq <= 1'b0;
    end
  end

`ifdef ETH_TX_SCHED_WATCHDOG_EN
  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_ACTIVE) r_wdog <= r_wdog + 13'd1;
      else                     r_wdog <= '0;
      if (w_kill)           r_err <= 1'b1;
      else if (bus.irq_ack) r_err <= 1'b0;
    end
  end

  assign bus.tx_kill     = w_kill;
  assign bus.err_timeout = r_err;
`else
  assign bus.tx_kill     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.desc_ready = w_desc_ready;
  assign bus.tx_start   = (r_state == S_START);
  assign bus.tx_base    = r_tx_base;
  assign bus.tx_len     = r_tx_len;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.q_count    = r_count;
  assign bus.done_count = r_done_cnt;
  assign bus.irq        = r_irq;
endmodule
